// File: rtl/rob_flush_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rob_flush_ctrl_pkg
// Shared types and defaults for the reorder-buffer flush controller.
//   rob_idx_t    : entry index for the default 8-entry buffer
//   rob_state_e  : controller state, NORMAL or RECOVER (post-flush stall)
//   *_DEFAULT    : default entry count and recovery window length
// ---------------------------------------------------------------------------
package rob_flush_ctrl_pkg;

  localparam int ROB_SIZE_DEFAULT       = 8;
  localparam int RECOVER_CYCLES_DEFAULT = 1;

  typedef logic [$clog2(ROB_SIZE_DEFAULT)-1:0] rob_idx_t;

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } rob_state_e;

endpackage

// File: rtl/rob_flush_ctrl_if.sv
// ---------------------------------------------------------------------------
// rob_flush_ctrl_if
// Bundles the allocation, commit and flush handshakes plus the buffer status
// of the reorder-buffer flush controller.
//   master : the surrounding pipeline (drives requests, observes status)
//   slave  : the controller itself
// Signals:
//   alloc_req / alloc_ready / alloc_idx   - allocation at the front pointer
//   commit_req / commit_ack / commit_idx  - retirement at the back pointer
//   flush_req / flush_mask                - per-entry kill request
//   valid_o, front_ptr, back_ptr, count, empty, full, recovering - status
// ---------------------------------------------------------------------------
interface rob_flush_ctrl_if #(
  parameter int SIZE = 8
);

  localparam int IW = $clog2(SIZE);

  logic            alloc_req;
  logic            alloc_ready;
  logic [IW-1:0]   alloc_idx;
  logic            commit_req;
  logic            commit_ack;
  logic [IW-1:0]   commit_idx;
  logic            flush_req;
  logic [SIZE-1:0] flush_mask;
  logic [SIZE-1:0] valid_o;
  logic [IW-1:0]   front_ptr;
  logic [IW-1:0]   back_ptr;
  logic [IW:0]     count;
  logic            empty;
  logic            full;
  logic            recovering;

  modport master (
    output alloc_req, commit_req, flush_req, flush_mask,
    input  alloc_ready, alloc_idx, commit_ack, commit_idx,
           valid_o, front_ptr, back_ptr, count, empty, full, recovering
  );

  modport slave (
    input  alloc_req, commit_req, flush_req, flush_mask,
    output alloc_ready, alloc_idx, commit_ack, commit_idx,
           valid_o, front_ptr, back_ptr, count, empty, full, recovering
  );

endinterface

// File: rtl/rob_flush_ctrl_flush_front_search.sv
// ---------------------------------------------------------------------------
// rob_flush_ctrl_flush_front_search
// Combinational search for the oldest entry that a flush kills.
//   valid, flush_mask : per-entry valid bits and kill request
//   back_ptr, count   : start and length of the occupied circular region
//   k                 : index of the oldest valid, masked entry
//   found             : such an entry exists inside the occupied region
// ---------------------------------------------------------------------------
module rob_flush_ctrl_flush_front_search #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0]          valid,
  input  logic [SIZE-1:0]          flush_mask,
  input  logic [$clog2(SIZE)-1:0]  back_ptr,
  input  logic [$clog2(SIZE):0]    count,
  output logic [$clog2(SIZE)-1:0]  k,
  output logic                     found
);

  localparam int IW = $clog2(SIZE);
  localparam int CW = IW + 1;

  logic [SIZE-1:0]   cand;
  logic [2*SIZE-1:0] dbl;
  logic [SIZE-1:0]   rot;
  logic [IW-1:0]     off;

  // Rotate the candidate bits so the oldest entry sits at bit 0, then pick
  // the lowest set bit within the first count positions. The loop runs from
  // the top down so the lowest matching position is the one that sticks.
  always_comb begin
    cand  = valid & flush_mask;
    dbl   = {cand, cand} >> back_ptr;
    rot   = dbl[SIZE-1:0];
    found = 1'b0;
    off   = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (rot[i] && (CW'(i) < count)) begin
        found = 1'b1;
        off   = IW'(i);
      end
    end
    k = back_ptr + off;
  end

endmodule

// File: rtl/rob_flush_ctrl.sv
// ---------------------------------------------------------------------------
// rob_flush_ctrl
// Pointer and valid-bit controller for a circular in-order buffer (e.g. the
// reorder buffer). Entries are allocated at front_ptr, retired at back_ptr,
// and a flush squashes everything from the oldest killed entry to the
// youngest, rewinds front_ptr and stalls allocation for RECOVER_CYCLES.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : rob_flush_ctrl_if.slave (alloc / commit / flush / status)
// ---------------------------------------------------------------------------
module rob_flush_ctrl
  import rob_flush_ctrl_pkg::*;
#(
  parameter int SIZE           = ROB_SIZE_DEFAULT,
  parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  rob_flush_ctrl_if.slave  bus
);

  localparam int IW = $clog2(SIZE);
  localparam int CW = IW + 1;

  logic [SIZE-1:0] valid_q, valid_d;
  logic [IW-1:0]   front_q, front_d;
  logic [IW-1:0]   back_q, back_d;
  logic [CW-1:0]   count_q, count_d;
  rob_state_e      state_q, state_d;
  logic [3:0]      rcnt_q, rcnt_d;

  logic            full_w;
  logic            empty_w;
  logic            alloc_ready_w;
  logic            commit_ack_w;
  logic            alloc_fire;
  logic            flush_eff;
  logic [IW-1:0]   k;
  logic            found;
  logic [IW-1:0]   k_off;
  logic [IW-1:0]   rel;

  rob_flush_ctrl_flush_front_search #(
    .SIZE (SIZE)
  ) u_search (
    .valid      (valid_q),
    .flush_mask (bus.flush_mask),
    .back_ptr   (back_q),
    .count      (count_q),
    .k          (k),
    .found      (found)
  );

  // Handshake qualifiers. A commit never retires an entry that is being
  // killed in the same cycle, which guarantees k != back_ptr on an ack.
  always_comb begin
    full_w        = (count_q == CW'(SIZE));
    empty_w       = (count_q == '0);
    alloc_ready_w = (state_q == NORMAL) && !full_w && !bus.flush_req;
    commit_ack_w  = bus.commit_req && valid_q[back_q] &&
                    !(bus.flush_req && bus.flush_mask[back_q]);
    alloc_fire    = bus.alloc_req && alloc_ready_w;
    flush_eff     = bus.flush_req && found;
    k_off         = k - back_q;
  end

  // Next-state computation. The commit acts on the pre-flush back pointer;
  // a flush kills every entry whose age offset lies in [k_off, count) and
  // the surviving count is k_off less any same-cycle retirement. Allocation
  // cannot coincide with a flush because flush_req drops alloc_ready.
  always_comb begin
    valid_d = valid_q;
    front_d = front_q;
    back_d  = back_q;
    count_d = count_q;
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rel     = '0;

    if (commit_ack_w) begin
      valid_d[back_q] = 1'b0;
      back_d          = back_q + IW'(1);
    end

    if (flush_eff) begin
      for (int i = 0; i < SIZE; i++) begin
        rel = IW'(i) - back_q;
        if ((rel >= k_off) && (CW'(rel) < count_q)) begin
          valid_d[i] = 1'b0;
        end
      end
      front_d = k;
      count_d = CW'(k_off) - CW'(commit_ack_w);
    end else begin
      if (alloc_fire) begin
        valid_d[front_q] = 1'b1;
        front_d          = front_q + IW'(1);
      end
      count_d = count_q + CW'(alloc_fire) - CW'(commit_ack_w);
    end

    // Recovery window: an effective flush (re)loads the counter, otherwise
    // RECOVER counts down and leaves after the cycle that holds 1.
    if (flush_eff) begin
      state_d = RECOVER;
      rcnt_d  = 4'(RECOVER_CYCLES);
    end else if (state_q == RECOVER) begin
      if (rcnt_q <= 4'd1) begin
        state_d = NORMAL;
        rcnt_d  = 4'd0;
      end else begin
        rcnt_d  = rcnt_q - 4'd1;
      end
    end
  end

  // All controller state, including the FSM, lives in this one register
  // block and clears immediately on reset, even in the middle of recovery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      front_q <= '0;
      back_q  <= '0;
      count_q <= '0;
      state_q <= NORMAL;
      rcnt_q  <= 4'd0;
    end else begin
      valid_q <= valid_d;
      front_q <= front_d;
      back_q  <= back_d;
      count_q <= count_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign bus.alloc_ready = alloc_ready_w;
  assign bus.alloc_idx   = front_q;
  assign bus.commit_ack  = commit_ack_w;
  assign bus.commit_idx  = back_q;
  assign bus.valid_o     = valid_q;
  assign bus.front_ptr   = front_q;
  assign bus.back_ptr    = back_q;
  assign bus.count       = count_q;
  assign bus.empty       = empty_w;
  assign bus.full        = full_w;
  assign bus.recovering  = (state_q == RECOVER);

endmodule

// File: tb/tb_rob_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rob_flush_ctrl
// Self-checking bench for rob_flush_ctrl (SIZE=8, RECOVER_CYCLES=3).
// The reference model keeps only the oldest index, the occupancy and the
// remaining recovery cycles; valid bits and the front pointer are derived.
// ---------------------------------------------------------------------------
module tb_rob_flush_ctrl;

  localparam int SIZE = 8;
  localparam int R    = 3;
  localparam int IW   = $clog2(SIZE);

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  int m_back  = 0;
  int m_count = 0;
  int m_rec   = 0;

  always #5 clk = ~clk;

  rob_flush_ctrl_if #(.SIZE(SIZE)) bus ();

  rob_flush_ctrl #(
    .SIZE           (SIZE),
    .RECOVER_CYCLES (R)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Occupied entries are exactly the circular run starting at m_back.
  function automatic logic [SIZE-1:0] m_valid();
    logic [SIZE-1:0] v;
    v = '0;
    for (int i = 0; i < m_count; i++) v[(m_back + i) % SIZE] = 1'b1;
    return v;
  endfunction

  function automatic int m_front();
    return (m_back + m_count) % SIZE;
  endfunction

  // Apply one cycle of the behavioural rules to the current inputs.
  task automatic model_step();
    logic ack, acc, found;
    int   off;
    ack   = bus.commit_req && (m_count > 0) &&
            !(bus.flush_req && bus.flush_mask[m_back]);
    acc   = bus.alloc_req && (m_rec == 0) && (m_count < SIZE) && !bus.flush_req;
    found = 1'b0;
    off   = 0;
    if (bus.flush_req)
      for (int i = 0; i < m_count; i++)
        if (!found && bus.flush_mask[(m_back + i) % SIZE]) begin
          found = 1'b1;
          off   = i;
        end
    if (found) begin
      m_count = off - int'(ack);
      m_back  = (m_back + int'(ack)) % SIZE;
      m_rec   = R;
    end else begin
      m_count = m_count + int'(acc) - int'(ack);
      m_back  = (m_back + int'(ack)) % SIZE;
      if (m_rec > 0) m_rec--;
    end
  endtask

  // Inputs change just after the falling edge and settle before sampling.
  task automatic set_in(input logic a, input logic c, input logic f,
                        input logic [SIZE-1:0] m);
    bus.alloc_req  = a;
    bus.commit_req = c;
    bus.flush_req  = f;
    bus.flush_mask = m;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, '0);
    m_back = 0; m_count = 0; m_rec = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, '0);
    m_back = 0; m_count = 0; m_rec = 0;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.front_ptr, bus.back_ptr, bus.count, bus.valid_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got f=%0d b=%0d c=%0d v=%b required all zero",
               bus.front_ptr, bus.back_ptr, bus.count, bus.valid_o);
    end
    checks++;
    if ({bus.empty, bus.full, bus.recovering, bus.commit_ack, bus.alloc_ready} !== 5'b10001) begin
      errors++;
      $display("[TB] FAIL reset_flags: got e/f/r/ack/ar=%b required 10001",
               {bus.empty, bus.full, bus.recovering, bus.commit_ack, bus.alloc_ready});
    end
    bus.commit_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < SIZE; i++) begin
      set_in(1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (bus.alloc_ready !== 1'b1 || bus.alloc_idx !== IW'(i)) begin
        errors++;
        $display("[TB] FAIL fill_grant: got ready=%b idx=%0d required ready=1 idx=%0d",
                 bus.alloc_ready, bus.alloc_idx, i);
      end
      tick();
    end
    set_in(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (bus.full !== 1'b1 || bus.alloc_ready !== 1'b0 || bus.count !== 4'd8) begin
      errors++;
      $display("[TB] FAIL fill_full: got full=%b ready=%b count=%0d required 1 0 8",
               bus.full, bus.alloc_ready, bus.count);
    end
    tick();
    checks++;
    if (bus.front_ptr !== 3'd0 || bus.count !== 4'd8) begin
      errors++;
      $display("[TB] FAIL fill_ninth: got front=%0d count=%0d required 0 8",
               bus.front_ptr, bus.count);
    end
  endtask

  task automatic test_wrap_flush();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (bus.commit_ack !== 1'b1 || bus.commit_idx !== IW'(i)) begin
        errors++;
        $display("[TB] FAIL wrap_commit: got ack=%b idx=%0d required 1 %0d",
                 bus.commit_ack, bus.commit_idx, i);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 1'b0, '0);
      tick();
    end
    checks++;
    if (bus.front_ptr !== 3'd3 || bus.back_ptr !== 3'd5) begin
      errors++;
      $display("[TB] FAIL wrap_ptrs: got front=%0d back=%0d required 3 5",
               bus.front_ptr, bus.back_ptr);
    end
    set_in(1'b0, 1'b0, 1'b1, 8'b0000_0100);
    tick();
    checks++;
    if (bus.front_ptr !== 3'd2 || bus.count !== 4'd5 || bus.valid_o !== 8'b1110_0011 ||
        bus.recovering !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_flush: got front=%0d count=%0d valid=%b rec=%b required 2 5 11100011 1",
               bus.front_ptr, bus.count, bus.valid_o, bus.recovering);
    end
    for (int i = 0; i < R; i++) begin
      set_in(1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (bus.recovering !== 1'b1 || bus.alloc_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wrap_window: cycle %0d got rec=%b ready=%b required 1 0",
                 i, bus.recovering, bus.alloc_ready);
      end
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (bus.recovering !== 1'b0 || bus.alloc_ready !== 1'b1 || bus.count !== 4'd5) begin
      errors++;
      $display("[TB] FAIL wrap_exit: got rec=%b ready=%b count=%0d required 0 1 5",
               bus.recovering, bus.alloc_ready, bus.count);
    end
  endtask

  task automatic test_full_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin set_in(1'b1, 1'b0, 1'b0, '0); tick(); end
    for (int i = 0; i < 4; i++) begin set_in(1'b0, 1'b1, 1'b0, '0); tick(); end
    for (int i = 0; i < 8; i++) begin set_in(1'b1, 1'b0, 1'b0, '0); tick(); end
    checks++;
    if (bus.full !== 1'b1 || bus.front_ptr !== 3'd4 || bus.back_ptr !== 3'd4) begin
      errors++;
      $display("[TB] FAIL fullfl_setup: got full=%b front=%0d back=%0d required 1 4 4",
               bus.full, bus.front_ptr, bus.back_ptr);
    end
    set_in(1'b0, 1'b0, 1'b1, 8'b0100_0001);
    tick();
    checks++;
    if (bus.front_ptr !== 3'd6 || bus.count !== 4'd2 || bus.valid_o !== 8'b0011_0000 ||
        bus.back_ptr !== 3'd4) begin
      errors++;
      $display("[TB] FAIL fullfl_result: got front=%0d count=%0d valid=%b back=%0d required 6 2 00110000 4",
               bus.front_ptr, bus.count, bus.valid_o, bus.back_ptr);
    end
  endtask

  task automatic test_commit_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin set_in(1'b1, 1'b0, 1'b0, '0); tick(); end
    set_in(1'b0, 1'b1, 1'b0, '0);
    tick();
    set_in(1'b0, 1'b1, 1'b1, 8'b0000_1000);
    checks++;
    if (bus.commit_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cf_ack: got ack=%b required 1", bus.commit_ack);
    end
    tick();
    checks++;
    if (bus.back_ptr !== 3'd2 || bus.front_ptr !== 3'd3 || bus.count !== 4'd1 ||
        bus.valid_o !== 8'b0000_0100) begin
      errors++;
      $display("[TB] FAIL cf_result: got back=%0d front=%0d count=%0d valid=%b required 2 3 1 00000100",
               bus.back_ptr, bus.front_ptr, bus.count, bus.valid_o);
    end
  endtask

  task automatic test_ineffective();
    for (int i = 0; i < R; i++) begin set_in(1'b0, 1'b0, 1'b0, '0); tick(); end
    set_in(1'b0, 1'b0, 1'b1, 8'b1111_1011);
    tick();
    set_in(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (bus.front_ptr !== 3'd3 || bus.back_ptr !== 3'd2 || bus.count !== 4'd1 ||
        bus.recovering !== 1'b0 || bus.alloc_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ineff: got front=%0d back=%0d count=%0d rec=%b ready=%b required 3 2 1 0 1",
               bus.front_ptr, bus.back_ptr, bus.count, bus.recovering, bus.alloc_ready);
    end
  endtask

  task automatic test_reload_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin set_in(1'b1, 1'b0, 1'b0, '0); tick(); end
    set_in(1'b0, 1'b0, 1'b1, 8'b0010_0000);
    tick();
    set_in(1'b1, 1'b0, 1'b0, '0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 8'b0001_0000);
    tick();
    for (int i = 0; i < R; i++) begin
      set_in(1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (bus.alloc_ready !== 1'b0 || bus.recovering !== 1'b1 || bus.count !== 4'd4) begin
        errors++;
        $display("[TB] FAIL reload_window: cycle %0d got ready=%b rec=%b count=%0d required 0 1 4",
                 i, bus.alloc_ready, bus.recovering, bus.count);
      end
      tick();
    end
    set_in(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (bus.alloc_ready !== 1'b1 || bus.front_ptr !== 3'd4) begin
      errors++;
      $display("[TB] FAIL reload_exit: got ready=%b front=%0d required 1 4",
               bus.alloc_ready, bus.front_ptr);
    end
    tick();
    set_in(1'b0, 1'b0, 1'b1, 8'b0000_0001);
    tick();
    set_in(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (bus.recovering !== 1'b1 || bus.empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL kback_flush: got rec=%b empty=%b required 1 1",
               bus.recovering, bus.empty);
    end
    #2;
    rst = 1'b1;
    #1;
    m_back = 0; m_count = 0; m_rec = 0;
    checks++;
    if ({bus.front_ptr, bus.back_ptr, bus.count, bus.valid_o} !== '0 ||
        {bus.empty, bus.full, bus.recovering, bus.alloc_ready} !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL midrec_reset: got f=%0d b=%0d c=%0d v=%b e/f/r/ar=%b required zeros and 1001",
               bus.front_ptr, bus.back_ptr, bus.count, bus.valid_o,
               {bus.empty, bus.full, bus.recovering, bus.alloc_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_random();
    logic            a, c, f, e_ar, e_ack;
    logic [SIZE-1:0] m;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      a = ($urandom_range(0, 9) < 6);
      c = ($urandom_range(0, 9) < 4);
      f = ($urandom_range(0, 9) == 0);
      m = SIZE'($urandom & $urandom);
      set_in(a, c, f, m);
      e_ar  = (m_rec == 0) && (m_count < SIZE) && !f;
      e_ack = c && (m_count > 0) && !(f && m[m_back]);
      checks++;
      if ({bus.alloc_ready, bus.commit_ack, bus.alloc_idx, bus.commit_idx} !==
          {e_ar, e_ack, IW'(m_front()), IW'(m_back)}) begin
        errors++;
        $display("[TB] FAIL rand_hs: n=%0d got ar=%b ack=%b ai=%0d ci=%0d required %b %b %0d %0d",
                 n, bus.alloc_ready, bus.commit_ack, bus.alloc_idx, bus.commit_idx,
                 e_ar, e_ack, m_front(), m_back);
      end
      checks++;
      if ({bus.front_ptr, bus.back_ptr, bus.count, bus.valid_o,
           bus.empty, bus.full, bus.recovering} !==
          {IW'(m_front()), IW'(m_back), 4'(m_count), m_valid(),
           (m_count == 0), (m_count == SIZE), (m_rec > 0)}) begin
        errors++;
        $display("[TB] FAIL rand_state: n=%0d got f=%0d b=%0d c=%0d v=%b e=%b fu=%b r=%b required %0d %0d %0d %b %b %b %b",
                 n, bus.front_ptr, bus.back_ptr, bus.count, bus.valid_o, bus.empty,
                 bus.full, bus.recovering, m_front(), m_back, m_count, m_valid(),
                 (m_count == 0), (m_count == SIZE), (m_rec > 0));
      end
      tick();
    end
  endtask

  initial begin
    bus.alloc_req  = 1'b0;
    bus.commit_req = 1'b0;
    bus.flush_req  = 1'b0;
    bus.flush_mask = '0;
    test_reset();
    test_fill();
    test_wrap_flush();
    test_full_flush();
    test_commit_flush();
    test_ineffective();
    test_reload_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
